// File: rtl/cpu_pkg.sv
// Shared types for the SLURM32 issue controller: register-select width,
// controller state encoding and the registered issue-slot layout.
package cpu_pkg;

  localparam int REG_BITS = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [REG_BITS-1:0] regA;
    logic [REG_BITS-1:0] regB;
    logic [REG_BITS-1:0] wr_sel;
    logic                wr_en;
  } issue_slot_t;

endpackage

// File: rtl/cpu_scoreboard.sv
// Pending-write scoreboard: one bit per register (r0 hardwired clear),
// RAW checks on two sources plus a WAW check on the destination, and a
// count of writes that have issued but not yet written back.
// With HAZARD_WB_BYPASS_EN defined, a bit being cleared by writeback this
// cycle is not reported as a hazard.
module cpu_scoreboard
  import cpu_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_BITS     = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                clr_all,
  input  logic                set_en,
  input  logic [REG_BITS-1:0] set_sel,
  input  logic                clr_en,
  input  logic [REG_BITS-1:0] clr_sel,
  input  logic [REG_BITS-1:0] rd_a_sel,
  input  logic                rd_a_use,
  input  logic [REG_BITS-1:0] rd_b_sel,
  input  logic                rd_b_use,
  input  logic [REG_BITS-1:0] chk_w_sel,
  input  logic                chk_w_use,
  output logic                hazard,
  output logic                clr_hit,
  output logic [CNT_BITS-1:0] inflight
);

  localparam int NREG = 1 << REG_BITS;

  logic [NREG-1:0]     sb_reg;
  logic [NREG-1:0]     sb_next;
  logic [CNT_BITS-1:0] inflight_reg;
  logic [CNT_BITS-1:0] inflight_next;
  logic                set_bit;
  logic                clr_bit;
  logic                byp_a;
  logic                byp_b;
  logic                byp_w;
  logic                hit_a;
  logic                hit_b;
  logic                hit_w;

  // Writes to r0 are never tracked; clears only act on a pending bit.
  assign set_bit = set_en && (set_sel != '0);
  assign clr_hit = (clr_sel != '0) && sb_reg[clr_sel];
  assign clr_bit = clr_en && clr_hit;

  // Per-bit next value: flush clears all, a new set beats a same-cycle clear.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign sb_next[gi] = 1'b0;
      end else begin : g_live
        assign sb_next[gi] = clr_all ? 1'b0 :
                             (set_bit && (set_sel == REG_BITS'(gi))) ? 1'b1 :
                             (clr_bit && (clr_sel == REG_BITS'(gi))) ? 1'b0 :
                             sb_reg[gi];
      end
    end
  endgenerate

`ifdef HAZARD_WB_BYPASS_EN
  assign byp_a = clr_bit && (clr_sel == rd_a_sel);
  assign byp_b = clr_bit && (clr_sel == rd_b_sel);
  assign byp_w = clr_bit && (clr_sel == chk_w_sel);
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
  assign byp_w = 1'b0;
`endif

  assign hit_a  = rd_a_use  && (rd_a_sel  != '0) && sb_reg[rd_a_sel]  && !byp_a;
  assign hit_b  = rd_b_use  && (rd_b_sel  != '0) && sb_reg[rd_b_sel]  && !byp_b;
  assign hit_w  = chk_w_use && (chk_w_sel != '0) && sb_reg[chk_w_sel] && !byp_w;
  assign hazard = hit_a || hit_b || hit_w;

  // Outstanding-write count: a set and a clear in one cycle cancel out.
  always_comb begin
    inflight_next = inflight_reg;
    if (clr_all) begin
      inflight_next = '0;
    end else if (set_bit && !clr_bit) begin
      inflight_next = inflight_reg + CNT_BITS'(1);
    end else if (!set_bit && clr_bit) begin
      inflight_next = inflight_reg - CNT_BITS'(1);
    end
  end

  // Scoreboard and counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sb_reg       <= '0;
      inflight_reg <= '0;
    end else begin
      sb_reg       <= sb_next;
      inflight_reg <= inflight_next;
    end
  end

  assign inflight = inflight_reg;

endmodule

// File: rtl/cpu_hazard_ctrl.sv
// Issue controller between decode and execute. Accepts decoded instructions
// into a single registered issue slot, stalls decode on RAW/WAW hazards or
// when too many writes are outstanding, and squashes state on flush.
// Optional macro: HAZARD_WB_BYPASS_EN lets a dependent instruction issue in
// the same cycle its source/destination is written back.
module cpu_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                dec_valid,
  output logic                dec_ready,
  input  logic [REG_BITS-1:0] dec_regA_sel,
  input  logic [REG_BITS-1:0] dec_regB_sel,
  input  logic                dec_useA,
  input  logic                dec_useB,
  input  logic                dec_wr_en,
  input  logic [REG_BITS-1:0] dec_wr_sel,
  output logic                issue_valid,
  output logic [REG_BITS-1:0] issue_regA_sel,
  output logic [REG_BITS-1:0] issue_regB_sel,
  output logic [REG_BITS-1:0] issue_wr_sel,
  output logic                issue_wr_en,
  input  logic                ex_stall,
  input  logic                wb_valid,
  input  logic [REG_BITS-1:0] wb_sel,
  input  logic                flush,
  output logic [15:0]         stall_count,
  output logic                wb_err
);

  localparam int CNT_BITS = $clog2(MAX_INFLIGHT + 1);

  state_t              state_reg;
  state_t              state_next;
  logic [3:0]          flush_cnt_reg;
  logic [3:0]          flush_cnt_next;
  issue_slot_t         issue_reg;
  logic                issue_valid_reg;
  logic [15:0]         stall_count_reg;
  logic                wb_err_reg;
  logic                hazard;
  logic                wb_hit;
  logic [CNT_BITS-1:0] inflight;
  logic                wb_live;
  logic                wb_ok;
  logic                full;
  logic                slot_free;
  logic                accept;

  // Writeback is ignored while flushing or on the flush cycle itself.
  assign wb_live   = !flush && (state_reg != FLUSH);
  assign wb_ok     = wb_valid && wb_live && wb_hit;
  assign full      = (inflight == CNT_BITS'(MAX_INFLIGHT)) && dec_wr_en;
  assign slot_free = !issue_valid_reg || !ex_stall;
  assign dec_ready = (state_reg != FLUSH) && !hazard && !full && slot_free && !flush;
  assign accept    = dec_valid && dec_ready;

  cpu_scoreboard #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNT_BITS     (CNT_BITS)
  ) u_sb (
    .CLK       (CLK),
    .RST       (RST),
    .clr_all   (flush),
    .set_en    (accept && dec_wr_en),
    .set_sel   (dec_wr_sel),
    .clr_en    (wb_ok),
    .clr_sel   (wb_sel),
    .rd_a_sel  (dec_regA_sel),
    .rd_a_use  (dec_useA),
    .rd_b_sel  (dec_regB_sel),
    .rd_b_use  (dec_useB),
    .chk_w_sel (dec_wr_sel),
    .chk_w_use (dec_wr_en),
    .hazard    (hazard),
    .clr_hit   (wb_hit),
    .inflight  (inflight)
  );

  // Next-state logic; flush overrides everything and reloads the counter.
  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    if (flush) begin
      state_next     = FLUSH;
      flush_cnt_next = 4'(FLUSH_CYCLES - 1);
    end else begin
      case (state_reg)
        RUN: begin
          if (dec_valid && !dec_ready) state_next = STALL;
        end
        STALL: begin
          if (accept || !dec_valid) state_next = RUN;
        end
        FLUSH: begin
          if (flush_cnt_reg == 4'd0) state_next = RUN;
          else flush_cnt_next = flush_cnt_reg - 4'd1;
        end
        default: state_next = RUN;
      endcase
    end
  end

  // State and flush-counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= RUN;
      flush_cnt_reg <= 4'd0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  // Issue slot: load on accept, hold while execute stalls, empty when consumed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      issue_reg       <= '0;
      issue_valid_reg <= 1'b0;
    end else if (flush) begin
      issue_valid_reg <= 1'b0;
    end else if (accept) begin
      issue_reg.regA   <= dec_regA_sel;
      issue_reg.regB   <= dec_regB_sel;
      issue_reg.wr_sel <= dec_wr_sel;
      issue_reg.wr_en  <= dec_wr_en;
      issue_valid_reg  <= 1'b1;
    end else if (issue_valid_reg && !ex_stall) begin
      issue_valid_reg <= 1'b0;
    end
  end

  // Saturating count of cycles spent in STALL.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_count_reg <= 16'd0;
    end else if ((state_reg == STALL) && (stall_count_reg != 16'hFFFF)) begin
      stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

  // Sticky error for a writeback to a register that was not pending.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wb_err_reg <= 1'b0;
    end else if (wb_valid && wb_live && !wb_hit) begin
      wb_err_reg <= 1'b1;
    end
  end

  assign issue_valid    = issue_valid_reg;
  assign issue_regA_sel = issue_reg.regA;
  assign issue_regB_sel = issue_reg.regB;
  assign issue_wr_sel   = issue_reg.wr_sel;
  assign issue_wr_en    = issue_reg.wr_en;
  assign stall_count    = stall_count_reg;
  assign wb_err         = wb_err_reg;

endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// Self-checking bench for cpu_hazard_ctrl: expected issue slots are queued
// when an instruction is driven and compared when the slot loads.
module tb_cpu_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       dec_valid, dec_ready, dec_useA, dec_useB, dec_wr_en;
  logic [7:0] dec_regA_sel, dec_regB_sel, dec_wr_sel;
  logic       issue_valid, issue_wr_en;
  logic [7:0] issue_regA_sel, issue_regB_sel, issue_wr_sel;
  logic       ex_stall, wb_valid, flush, wb_err;
  logic [7:0] wb_sel;
  logic [15:0] stall_count;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [24:0] exp_q[$];
  logic [24:0] exp_slot;
  logic [24:0] act_slot;

`ifdef HAZARD_WB_BYPASS_EN
  localparam int EXP_STALLS = 4;
`else
  localparam int EXP_STALLS = 5;
`endif

  assign act_slot = {issue_wr_en, issue_wr_sel, issue_regA_sel, issue_regB_sel};

  always #5 CLK = ~CLK;

  cpu_hazard_ctrl dut (
    .CLK(CLK), .RST(RST),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_regA_sel(dec_regA_sel), .dec_regB_sel(dec_regB_sel),
    .dec_useA(dec_useA), .dec_useB(dec_useB),
    .dec_wr_en(dec_wr_en), .dec_wr_sel(dec_wr_sel),
    .issue_valid(issue_valid), .issue_regA_sel(issue_regA_sel),
    .issue_regB_sel(issue_regB_sel), .issue_wr_sel(issue_wr_sel),
    .issue_wr_en(issue_wr_en), .ex_stall(ex_stall),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .flush(flush),
    .stall_count(stall_count), .wb_err(wb_err)
  );

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic drv(input logic v, input logic [7:0] a, input logic [7:0] b,
                     input logic ua, input logic ub, input logic we, input logic [7:0] ws);
    dec_valid = v; dec_regA_sel = a; dec_regB_sel = b;
    dec_useA = ua; dec_useB = ub; dec_wr_en = we; dec_wr_sel = ws;
  endtask

  task automatic push_exp(input logic we, input logic [7:0] ws, input logic [7:0] a, input logic [7:0] b);
    exp_q.push_back({we, ws, a, b});
  endtask

  task automatic test_reset();
    RST = 1'b1; ex_stall = 0; wb_valid = 0; wb_sel = 0; flush = 0;
    drv(0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc();
    #1;
    tests_run++; if (issue_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", issue_valid); end
    tests_run++; if (act_slot !== 25'd0) begin tests_failed++; $display("FAIL reset_slot got=%h exp=0", act_slot); end
    tests_run++; if (stall_count !== 16'd0) begin tests_failed++; $display("FAIL reset_stall got=%0d exp=0", stall_count); end
    tests_run++; if (wb_err !== 1'b0) begin tests_failed++; $display("FAIL reset_wberr got=%b exp=0", wb_err); end
    tests_run++; if (dec_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got=%b exp=1", dec_ready); end
    RST = 1'b0;
    cyc();
  endtask

  task automatic test_raw();
    drv(1, 3, 4, 1, 1, 1, 2); #1;
    tests_run++; if (dec_ready !== 1'b1) begin tests_failed++; $display("FAIL raw_add_ready got=%b exp=1", dec_ready); end
    push_exp(1, 2, 3, 4); cyc();
    exp_slot = exp_q.pop_front(); tests_run++;
    if (issue_valid !== 1'b1 || act_slot !== exp_slot) begin tests_failed++; $display("FAIL raw_add_issue got v=%b %h exp v=1 %h", issue_valid, act_slot, exp_slot); end
    tests_run++; if (dut.u_sb.sb_reg[2] !== 1'b1) begin tests_failed++; $display("FAIL raw_sb2 got=%b exp=1", dut.u_sb.sb_reg[2]); end
    drv(1, 2, 0, 1, 0, 0, 0); #1;
    tests_run++; if (dec_ready !== 1'b0) begin tests_failed++; $display("FAIL raw_dep_ready got=%b exp=0", dec_ready); end
    cyc();
    tests_run++; if (stall_count !== 16'd0) begin tests_failed++; $display("FAIL raw_stall0 got=%0d exp=0", stall_count); end
    for (int k = 1; k <= 3; k++) begin
      cyc();
      tests_run++; if (stall_count !== 16'(k)) begin tests_failed++; $display("FAIL raw_stall_cnt got=%0d exp=%0d", stall_count, k); end
      tests_run++; if (dec_ready !== 1'b0) begin tests_failed++; $display("FAIL raw_stall_ready got=%b exp=0", dec_ready); end
    end
    wb_valid = 1; wb_sel = 2; #1;
`ifdef HAZARD_WB_BYPASS_EN
    tests_run++; if (dec_ready !== 1'b1) begin tests_failed++; $display("FAIL raw_wb_bypass got=%b exp=1", dec_ready); end
    push_exp(0, 0, 2, 0); cyc();
    wb_valid = 0; drv(0, 0, 0, 0, 0, 0, 0);
`else
    tests_run++; if (dec_ready !== 1'b0) begin tests_failed++; $display("FAIL raw_wb_same got=%b exp=0", dec_ready); end
    cyc();
    wb_valid = 0; #1;
    tests_run++; if (dec_ready !== 1'b1) begin tests_failed++; $display("FAIL raw_wb_after got=%b exp=1", dec_ready); end
    push_exp(0, 0, 2, 0); cyc();
    drv(0, 0, 0, 0, 0, 0, 0);
`endif
    exp_slot = exp_q.pop_front(); tests_run++;
    if (issue_valid !== 1'b1 || act_slot !== exp_slot) begin tests_failed++; $display("FAIL raw_dep_issue got v=%b %h exp v=1 %h", issue_valid, act_slot, exp_slot); end
    cyc();
    tests_run++; if (stall_count !== 16'(EXP_STALLS)) begin tests_failed++; $display("FAIL raw_stall_total got=%0d exp=%0d", stall_count, EXP_STALLS); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drv(1, 0, 0, 0, 0, 1, 8'(5 + i)); #1;
      tests_run++; if (dec_ready !== 1'b1) begin tests_failed++; $display("FAIL full_wr%0d_ready got=%b exp=1", i, dec_ready); end
      push_exp(1, 8'(5 + i), 0, 0); cyc();
      exp_slot = exp_q.pop_front(); tests_run++;
      if (issue_valid !== 1'b1 || act_slot !== exp_slot) begin tests_failed++; $display("FAIL full_wr%0d_issue got v=%b %h exp v=1 %h", i, issue_valid, act_slot, exp_slot); end
    end
    drv(1, 0, 0, 0, 0, 1, 9); #1;
    tests_run++; if (dec_ready !== 1'b0) begin tests_failed++; $display("FAIL full_block got=%b exp=0", dec_ready); end
    drv(1, 1, 0, 1, 0, 0, 0); #1;
    tests_run++; if (dec_ready !== 1'b1) begin tests_failed++; $display("FAIL full_nonwriter got=%b exp=1", dec_ready); end
    push_exp(0, 0, 1, 0); cyc();
    exp_slot = exp_q.pop_front(); tests_run++;
    if (issue_valid !== 1'b1 || act_slot !== exp_slot) begin tests_failed++; $display("FAIL full_nonwriter_issue got v=%b %h exp v=1 %h", issue_valid, act_slot, exp_slot); end
    drv(1, 0, 0, 0, 0, 1, 9); #1;
    tests_run++; if (dec_ready !== 1'b0) begin tests_failed++; $display("FAIL full_block2 got=%b exp=0", dec_ready); end
    cyc();
    wb_valid = 1; wb_sel = 5; #1;
    tests_run++; if (dec_ready !== 1'b0) begin tests_failed++; $display("FAIL full_wb_same got=%b exp=0", dec_ready); end
    cyc();
    wb_valid = 0; #1;
    tests_run++; if (dec_ready !== 1'b1) begin tests_failed++; $display("FAIL full_after_wb got=%b exp=1", dec_ready); end
    push_exp(1, 9, 0, 0); cyc();
    drv(0, 0, 0, 0, 0, 0, 0);
    exp_slot = exp_q.pop_front(); tests_run++;
    if (issue_valid !== 1'b1 || act_slot !== exp_slot) begin tests_failed++; $display("FAIL full_wr9_issue got v=%b %h exp v=1 %h", issue_valid, act_slot, exp_slot); end
    cyc();
  endtask

  task automatic test_ex_stall();
    wb_valid = 1; wb_sel = 6; cyc();
    wb_sel = 7; cyc();
    wb_valid = 0; #1;
    tests_run++; if (wb_err !== 1'b0) begin tests_failed++; $display("FAIL exs_wb_pending_err got=%b exp=0", wb_err); end
    drv(1, 0, 0, 0, 0, 1, 2); #1;
    tests_run++; if (dec_ready !== 1'b1) begin tests_failed++; $display("FAIL exs_wr2_ready got=%b exp=1", dec_ready); end
    push_exp(1, 2, 0, 0); cyc();
    exp_slot = exp_q.pop_front(); tests_run++;
    if (issue_valid !== 1'b1 || act_slot !== exp_slot) begin tests_failed++; $display("FAIL exs_wr2_issue got v=%b %h exp v=1 %h", issue_valid, act_slot, exp_slot); end
    ex_stall = 1; drv(1, 0, 0, 0, 0, 1, 5);
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++; if (dec_ready !== 1'b0) begin tests_failed++; $display("FAIL exs_hold%0d_ready got=%b exp=0", k, dec_ready); end
      tests_run++; if (issue_valid !== 1'b1 || act_slot !== {1'b1, 8'd2, 8'd0, 8'd0}) begin tests_failed++; $display("FAIL exs_hold%0d_slot got v=%b %h exp v=1 %h", k, issue_valid, act_slot, {1'b1, 8'd2, 8'd0, 8'd0}); end
      cyc();
    end
    ex_stall = 0; #1;
    tests_run++; if (dec_ready !== 1'b1) begin tests_failed++; $display("FAIL exs_release_ready got=%b exp=1", dec_ready); end
    push_exp(1, 5, 0, 0); cyc();
    drv(0, 0, 0, 0, 0, 0, 0);
    exp_slot = exp_q.pop_front(); tests_run++;
    if (issue_valid !== 1'b1 || act_slot !== exp_slot) begin tests_failed++; $display("FAIL exs_wr5_issue got v=%b %h exp v=1 %h", issue_valid, act_slot, exp_slot); end
  endtask

  task automatic test_flush();
    ex_stall = 1; #1;
    tests_run++; if (dut.u_sb.sb_reg[2] !== 1'b1 || dut.u_sb.sb_reg[5] !== 1'b1) begin tests_failed++; $display("FAIL flush_pre_sb got=%b%b exp=11", dut.u_sb.sb_reg[2], dut.u_sb.sb_reg[5]); end
    flush = 1; wb_valid = 1; wb_sel = 3; #1;
    tests_run++; if (dec_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_cycle_ready got=%b exp=0", dec_ready); end
    cyc();
    flush = 0; wb_valid = 0; ex_stall = 0; drv(1, 0, 0, 0, 0, 1, 2); #1;
    tests_run++; if (issue_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_valid got=%b exp=0", issue_valid); end
    tests_run++; if (dut.u_sb.sb_reg !== '0) begin tests_failed++; $display("FAIL flush_sb_clear got=nonzero exp=0"); end
    tests_run++; if (wb_err !== 1'b0) begin tests_failed++; $display("FAIL flush_wb_ignored got=%b exp=0", wb_err); end
    tests_run++; if (dec_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_c1_ready got=%b exp=0", dec_ready); end
    cyc();
    wb_valid = 1; wb_sel = 4; #1;
    tests_run++; if (dec_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_c2_ready got=%b exp=0", dec_ready); end
    cyc();
    wb_valid = 0; #1;
    tests_run++; if (dec_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_done_ready got=%b exp=1", dec_ready); end
    tests_run++; if (wb_err !== 1'b0) begin tests_failed++; $display("FAIL flush_state_wb_err got=%b exp=0", wb_err); end
    push_exp(1, 2, 0, 0); cyc();
    exp_slot = exp_q.pop_front(); tests_run++;
    if (issue_valid !== 1'b1 || act_slot !== exp_slot) begin tests_failed++; $display("FAIL flush_wr2_issue got v=%b %h exp v=1 %h", issue_valid, act_slot, exp_slot); end
    for (int i = 1; i < 4; i++) begin
      drv(1, 0, 0, 0, 0, 1, 8'(2 + i)); #1;
      tests_run++; if (dec_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_refill%0d_ready got=%b exp=1", i, dec_ready); end
      push_exp(1, 8'(2 + i), 0, 0); cyc();
      exp_slot = exp_q.pop_front(); tests_run++;
      if (issue_valid !== 1'b1 || act_slot !== exp_slot) begin tests_failed++; $display("FAIL flush_refill%0d_issue got v=%b %h exp v=1 %h", i, issue_valid, act_slot, exp_slot); end
    end
    drv(1, 0, 0, 0, 0, 1, 6); #1;
    tests_run++; if (dec_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_refill_full got=%b exp=0", dec_ready); end
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc();
  endtask

  task automatic test_wb_err_reset();
    wb_valid = 1; wb_sel = 9; cyc();
    wb_valid = 0; #1;
    tests_run++; if (wb_err !== 1'b1) begin tests_failed++; $display("FAIL wberr_set got=%b exp=1", wb_err); end
    cyc();
    tests_run++; if (wb_err !== 1'b1) begin tests_failed++; $display("FAIL wberr_sticky got=%b exp=1", wb_err); end
    #2 RST = 1'b1; #1;
    tests_run++; if (wb_err !== 1'b0) begin tests_failed++; $display("FAIL arst_wberr got=%b exp=0", wb_err); end
    tests_run++; if (issue_valid !== 1'b0 || act_slot !== 25'd0) begin tests_failed++; $display("FAIL arst_slot got v=%b %h exp v=0 0", issue_valid, act_slot); end
    tests_run++; if (stall_count !== 16'd0) begin tests_failed++; $display("FAIL arst_stall got=%0d exp=0", stall_count); end
    drv(1, 0, 0, 0, 0, 1, 2); #1;
    tests_run++; if (dec_ready !== 1'b1) begin tests_failed++; $display("FAIL arst_sb_ready got=%b exp=1", dec_ready); end
    drv(0, 0, 0, 0, 0, 0, 0);
    RST = 1'b0;
    cyc();
    wb_valid = 1; wb_sel = 0; cyc();
    wb_valid = 0; #1;
    tests_run++; if (wb_err !== 1'b1) begin tests_failed++; $display("FAIL wberr_r0 got=%b exp=1", wb_err); end
  endtask

  task automatic test_back_to_back_r0();
    for (int i = 0; i < 5; i++) begin
      drv(1, 0, 0, 1, 1, 1, 0); #1;
      tests_run++; if (dec_ready !== 1'b1) begin tests_failed++; $display("FAIL r0_wr%0d_ready got=%b exp=1", i, dec_ready); end
      push_exp(1, 0, 0, 0); cyc();
      exp_slot = exp_q.pop_front(); tests_run++;
      if (issue_valid !== 1'b1 || act_slot !== exp_slot) begin tests_failed++; $display("FAIL r0_wr%0d_issue got v=%b %h exp v=1 %h", i, issue_valid, act_slot, exp_slot); end
    end
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_full();
    test_ex_stall();
    test_flush();
    test_wb_err_reset();
    test_back_to_back_r0();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cpu_hazard_ctrl.md
Name: cpu_hazard_ctrl

Overview:
- Issue controller between cpu_decode and execute in the SLURM32 pipeline.
- Holds decoded register selects in a scoreboard of pending writes and stalls decode on RAW/WAW hazards or when too many writes are in flight.
- Presents one registered issue slot to execute, and handles pipeline flush on branch/interrupt.

Parameters:
REG_BITS, 8, width of register selects (matches cpu_decode regA_sel/regB_sel)
MAX_INFLIGHT, 4, max outstanding register writes (issued, not written back)
FLUSH_CYCLES, 2, cycles spent in FLUSH before accepting again (1..15)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
dec_valid  in  1  decode presents an instruction
dec_ready  out  1  controller accepts this cycle (combinational)
dec_regA_sel  in  REG_BITS  source A select
dec_regB_sel  in  REG_BITS  source B select
dec_useA  in  1  instruction reads A
dec_useB  in  1  instruction reads B
dec_wr_en  in  1  instruction writes a register
dec_wr_sel  in  REG_BITS  destination select
issue_valid  out  1  issue slot occupied
issue_regA_sel / issue_regB_sel / issue_wr_sel  out  REG_BITS each  registered copies
issue_wr_en  out  1  registered copy
ex_stall  in  1  execute cannot take issue slot
wb_valid  in  1  writeback retiring a write this cycle
wb_sel  in  REG_BITS  register written back
flush  in  1  squash issue slot and pending state
stall_count  out  16  saturating count of STALL cycles
wb_err  out  1  sticky: wb_valid to a non-pending register

Behaviour:
- Reset: issue_* = 0, issue_valid = 0, scoreboard all clear, inflight = 0, stall_count = 0, wb_err = 0, state = RUN.
- Scoreboard: 2**REG_BITS bits. r0 is never marked (hardwired zero) and never causes a hazard.
- hazard = (useA & sb[regA]) | (useB & sb[regB]) | (wr_en & sb[wr_sel]), each term gated by sel != 0.
- full = (inflight == MAX_INFLIGHT) & dec_wr_en.
- slot_free = !issue_valid | !ex_stall.
- dec_ready = (state != FLUSH) & !hazard & !full & slot_free & !flush.
- Accept (dec_valid & dec_ready): next edge loads the issue_* registers and sets issue_valid = 1, giving 1-cycle latency. Also sets sb[wr_sel] if wr_en and wr_sel != 0, and increments inflight.
- Issue slot is held unchanged while issue_valid & ex_stall. If the slot is consumed with no new accept, issue_valid -> 0.
- Writeback: wb_valid clears sb[wb_sel] and decrements inflight.
  - Accept and wb in the same cycle: inflight unchanged.
  - Set and clear of the same bit in the same cycle: set wins.
  - wb_valid to a clear bit or wb_sel = 0: sb and inflight unchanged, wb_err <= 1.
- State RUN: dec_valid & !dec_ready & !flush -> STALL.
- State STALL: stall_count++ each cycle (saturates at 0xFFFF). dec_valid & dec_ready -> RUN; !dec_valid -> RUN.
- flush (any state, highest priority):
  - Next edge: issue_valid = 0, sb cleared, inflight = 0, state = FLUSH, flush counter loaded with FLUSH_CYCLES-1.
  - FLUSH decrements to 0, then -> RUN. flush reasserted in FLUSH reloads the counter.
  - wb_valid during FLUSH or on the flush cycle is ignored (no wb_err).
  - Squashed instructions never write back; execute guarantees this.
- Reset mid-operation: everything returns asynchronously to reset values.

Optional Feature:
- Macro HAZARD_WB_BYPASS_EN.
- Defined: a source/dest bit being cleared by wb_valid in the same cycle does not count as a hazard, so dependent instructions issue in the writeback cycle (regfile write-through assumed).
- Undefined: hazard uses the registered scoreboard only, so a dependent instruction issues one cycle after wb_valid.

Decomposition:
- Package cpu_pkg holds:
  - REG_BITS
  - state enum {RUN, STALL, FLUSH}
  - the issue-slot struct (regA, regB, wr_sel, wr_en)
- One natural sub-module, cpu_scoreboard: bit vector, set/clear ports, two read-check ports plus WAW check, and the inflight counter.

Test Plan:
- Reset, then ADD r2,r3,r4 (wr r2, A=r3, B=r4) -> dec_ready=1; one cycle later issue_valid=1, issue_wr_sel=2, sb[2]=1.
- Next instr reads r2 (A=2) with no wb -> dec_ready=0, state STALL, stall_count counts 1,2,3. wb_valid with wb_sel=2 -> issues on the following cycle; with HAZARD_WB_BYPASS_EN it issues in the same cycle.
- Four back-to-back independent writes r5..r8 with no wb -> fifth writer stalled (full). A non-writing instr still issues. One wb -> writer accepted.
- ex_stall held 3 cycles with issue_valid=1 -> issue_* stable, dec_ready=0. Release -> slot consumed and the next instr loads in that cycle.
- flush while sb[2], sb[5] set and issue_valid=1 -> next cycle issue_valid=0, sb clear, dec_ready=0 for FLUSH_CYCLES=2 cycles, then 1.
- wb_valid with wb_sel=9 not pending -> wb_err=1 and stays set. wb_sel=0 also sets wb_err. Writer to r0 never stalls.
